// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and default sizing for the CPU-side memory requester.
package mem_req_pkg;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } req_t;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous request FIFO; pointers and count reset asynchronously, storage does not.
module req_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_en);
            rd_ptr <= rd_ptr + PW'(rd_en);
            count  <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/cpu_mem_requester.sv
// cpu_mem_requester: queues CPU loads/stores and issues them one at a time to the memory system.
module cpu_mem_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ReqValid,
    output logic                         ReqReady,
    input  logic                         ReqWrite,
    input  logic [ADDR_W-1:0]            ReqAddr,
    input  logic [DATA_W-1:0]            ReqData,
    output logic                         RspValid,
    output logic                         RspWrite,
    output logic [DATA_W-1:0]            RspData,
    output logic                         RspTimeout,
    output logic                         MemReadCpu,
    output logic                         MemWriteCpu,
    output logic [ADDR_W-1:0]            Address,
    output logic [DATA_W-1:0]            DataIn,
    input  logic                         Stall,
    input  logic [DATA_W-1:0]            DataOut,
    output logic                         Busy,
    output logic [$clog2(DEPTH+1)-1:0]   PendingCount
);
    localparam int CW = $clog2(TIMEOUT);
    localparam int W  = 1 + ADDR_W + DATA_W;

    state_t        state, state_n;
    logic [CW-1:0] stall_cnt;
    logic [W-1:0]  head;
    logic          full, empty, pop, done, abort, iss_write;

    // The head stays queued until completion, so PendingCount includes the in-flight request.
    req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (ReqValid),
        .pop   (pop),
        .din   ({ReqWrite, ReqAddr, ReqData}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (PendingCount)
    );

    assign ReqReady    = !full;
    assign pop         = done || abort;
    assign MemReadCpu  = state == ISSUE && !iss_write;
    assign MemWriteCpu = state == ISSUE && iss_write;
    assign Busy        = state != IDLE || !empty;

    always_comb begin
        state_n = state;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE:  state_n = empty ? IDLE : ISSUE;
            ISSUE: begin
                done    = !Stall;
                abort   = Stall && stall_cnt == CW'(TIMEOUT-1);
                state_n = (done || abort) ? GAP : ISSUE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            iss_write  <= 1'b0;
            Address    <= '0;
            DataIn     <= '0;
            stall_cnt  <= '0;
            RspValid   <= 1'b0;
            RspWrite   <= 1'b0;
            RspData    <= '0;
            RspTimeout <= 1'b0;
        end else begin
            state    <= state_n;
            RspValid <= pop;
            if (state == IDLE && !empty) {iss_write, Address, DataIn} <= head;
            if (state != ISSUE) stall_cnt <= '0;
            else if (Stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (pop) begin
                RspWrite   <= iss_write;
                RspData    <= (done && !iss_write) ? DataOut : '0;
                RspTimeout <= abort;
            end
        end
    end
endmodule

// File: tb/tb_cpu_mem_requester.sv
// tb_cpu_mem_requester: directed timing checks plus random traffic against an in-order request scoreboard.
module tb_cpu_mem_requester;
    import mem_req_pkg::*;
    localparam int DEPTH = 4, TIMEOUT = 64;

    logic        CLK, RST, ReqValid, ReqReady, ReqWrite, RspValid, RspWrite, RspTimeout;
    logic        MemReadCpu, MemWriteCpu, Stall, Busy;
    logic [9:0]  ReqAddr, Address;
    logic [31:0] ReqData, RspData, DataIn, DataOut;
    logic [2:0]  PendingCount;

    int   n_cmp, n_err, cyc, rsp_cyc, acc_cyc, stall_run, strobe_cnt, n_rsp, n0, na;
    bit   prev_rsp;
    req_t q[$];
    int   rsp_cycs[$];

    cpu_mem_requester dut (
        .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .RspValid(RspValid), .RspWrite(RspWrite),
        .RspData(RspData), .RspTimeout(RspTimeout), .MemReadCpu(MemReadCpu),
        .MemWriteCpu(MemWriteCpu), .Address(Address), .DataIn(DataIn), .Stall(Stall),
        .DataOut(DataOut), .Busy(Busy), .PendingCount(PendingCount)
    );

    // Memory contents are a fixed function of address; 0x015 holds 0xDEADBEEF.
    function automatic logic [31:0] mem_word(logic [9:0] a);
        return 32'hDEADBEEF ^ {22'd0, a ^ 10'h015};
    endfunction
    assign DataOut = mem_word(Address);

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge and check every output against the scoreboard.
    task automatic step();
        logic st, sb;
        req_t e;
        st = Stall;
        sb = MemReadCpu | MemWriteCpu;
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        if (sb && st) stall_run++;
        chk("rsp_pulse", RspValid & prev_rsp, 0);
        prev_rsp = RspValid;
        if (RspValid) begin
            rsp_cyc = cyc;
            n_rsp++;
            rsp_cycs.push_back(cyc);
            chk("rsp_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rsp_write", RspWrite, e.write);
                chk("rsp_timeout", RspTimeout, st);
                chk("rsp_data", RspData, (e.write || st) ? 32'd0 : mem_word(e.addr));
                chk("rsp_from_issue", sb, 1);
                if (st) chk("timeout_len", stall_run, TIMEOUT);
            end
            stall_run = 0;
        end
        chk("pending", PendingCount, q.size());
        chk("ready", ReqReady, q.size() < DEPTH);
        chk("one_strobe", MemReadCpu & MemWriteCpu, 0);
        if (MemReadCpu | MemWriteCpu) begin
            strobe_cnt++;
            chk("strobe_has_req", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("mem_write", MemWriteCpu, q[0].write);
                chk("address", Address, q[0].addr);
                chk("data_in", DataIn, q[0].data);
            end
        end
        if (q.size() != 0) chk("busy", Busy, 1);
    endtask

    task automatic offer(logic w, logic [9:0] a, logic [31:0] d);
        req_t r;
        ReqValid = 1; ReqWrite = w; ReqAddr = a; ReqData = d;
        r.write = w; r.addr = a; r.data = d;
        if (q.size() < DEPTH) begin
            q.push_back(r);
            acc_cyc = cyc + 1;
        end
        step();
        ReqValid = 0;
    endtask

    task automatic wait_rsp(int bound);
        int s;
        s = n_rsp;
        for (int i = 0; i < bound && n_rsp == s; i++) step();
        chk("rsp_arrived", n_rsp > s, 1);
    endtask

    // Single request into an idle requester with S stall edges during ISSUE.
    task automatic lat_req(logic w, logic [9:0] a, logic [31:0] d, int s);
        strobe_cnt = 0;
        Stall = 0;
        offer(w, a, d);
        step();
        for (int i = 0; i < s; i++) begin
            Stall = 1;
            step();
        end
        Stall = 0;
        wait_rsp(4);
        chk("latency", rsp_cyc - acc_cyc, s + 2);
        chk("strobe_cycles", strobe_cnt, s + 1);
    endtask

    initial begin
        RST = 1; ReqValid = 0; ReqWrite = 0; ReqAddr = 0; ReqData = 0; Stall = 0;
        n_cmp = 0; n_err = 0; cyc = 0; stall_run = 0; n_rsp = 0; prev_rsp = 0;
        #12;
        chk("rst_ready", ReqReady, 1);
        chk("rst_rsp_valid", RspValid, 0);
        chk("rst_rsp_write", RspWrite, 0);
        chk("rst_rsp_timeout", RspTimeout, 0);
        chk("rst_rsp_data", RspData, 0);
        chk("rst_read", MemReadCpu, 0);
        chk("rst_write", MemWriteCpu, 0);
        chk("rst_address", Address, 0);
        chk("rst_data_in", DataIn, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_pending", PendingCount, 0);
        @(negedge CLK);
        RST = 0;

        lat_req(0, 10'h015, 32'h0, 0);
        chk("hit_data", RspData, 32'hDEADBEEF);
        step(); step();
        lat_req(0, 10'h3F0, 32'h0, 4);
        step(); step();
        lat_req(1, 10'h002, 32'h12345678, 3);
        chk("store_rsp_write", RspWrite, 1);
        chk("store_rsp_data", RspData, 0);
        step(); step();

        Stall = 1;
        for (int i = 0; i < 4; i++) offer(1'($urandom), 10'($urandom), $urandom);
        chk("full_ready", ReqReady, 0);
        offer(1, 10'h111, 32'h5555AAAA);
        chk("full_pending", PendingCount, 4);
        Stall = 0;
        rsp_cycs.delete();
        n0 = n_rsp;
        for (int i = 0; i < 20 && n_rsp < n0 + 4; i++) step();
        chk("full_rsps", n_rsp - n0, 4);
        for (int i = 1; i < rsp_cycs.size(); i++) chk("full_gap", rsp_cycs[i] - rsp_cycs[i-1], 3);
        step(); step();

        Stall = 1;
        offer(0, 10'h155, 32'h0);
        n0 = n_rsp;
        for (int i = 0; i < 80 && n_rsp == n0; i++) step();
        chk("tmo_rsp", n_rsp - n0, 1);
        chk("tmo_flag", RspTimeout, 1);
        chk("tmo_latency", rsp_cyc - acc_cyc, TIMEOUT + 1);
        step();
        chk("tmo_strobes", MemReadCpu | MemWriteCpu, 0);
        Stall = 0;
        step();
        lat_req(0, 10'h0AA, 32'h0, 0);
        chk("after_tmo_flag", RspTimeout, 0);
        step(); step();

        Stall = 1;
        offer(1, 10'h3FF, 32'hCAFEF00D);
        step(); step();
        chk("pre_rst_strobe", MemWriteCpu, 1);
        n0 = n_rsp;
        #2 RST = 1;
        #1;
        chk("mid_rst_write", MemWriteCpu, 0);
        chk("mid_rst_read", MemReadCpu, 0);
        chk("mid_rst_pending", PendingCount, 0);
        chk("mid_rst_rsp", RspValid, 0);
        chk("mid_rst_busy", Busy, 0);
        q.delete();
        stall_run = 0;
        prev_rsp = 0;
        @(negedge CLK);
        RST = 0;
        Stall = 0;
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_rsp", n_rsp - n0, 0);

        n0 = n_rsp;
        na = 0;
        for (int i = 0; i < 400; i++) begin
            Stall = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 1) == 1) begin
                if (q.size() < DEPTH) na++;
                offer(1'($urandom), 10'($urandom), $urandom);
            end else step();
        end
        Stall = 0;
        for (int i = 0; i < 60 && q.size() != 0; i++) step();
        step(); step();
        chk("rand_rsps", n_rsp - n0, na);
        chk("rand_idle", Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_mem_requester.md
# cpu_mem_requester

CPU-side initiator for the cache memory system: accepts load/store requests from a pipeline or bench through a valid/ready queue and drives the `MemReadCpu`, `MemWriteCpu`, `Address` and `DataIn` signals. It holds each request stable while `Stall` is high, captures `DataOut` on read completion, and returns one response per request. A watchdog aborts any request whose stall outlasts a bound.

## Interface
- `ADDR_W`, 10: address width; matches the memory system `Address`.
- `DATA_W`, 32: data word width.
- `DEPTH`, 4: request FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, 64: maximum consecutive `Stall` cycles per request before abort.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `ReqValid`  in  1: request offered.
- `ReqReady`  out  1: FIFO not full.
- `ReqWrite`  in  1: 1 = store, 0 = load.
- `ReqAddr`  in  ADDR_W: request address.
- `ReqData`  in  DATA_W: store data.
- `RspValid`  out  1: one-cycle response pulse.
- `RspWrite`  out  1: echoes `ReqWrite` of the completed request.
- `RspData`  out  DATA_W: load data; 0 for stores and timeouts.
- `RspTimeout`  out  1: qualifies `RspValid`; the request was aborted.
- `MemReadCpu`  out  1: read strobe to the memory system.
- `MemWriteCpu`  out  1: write strobe to the memory system.
- `Address`  out  ADDR_W: memory address.
- `DataIn`  out  DATA_W: store data to memory.
- `Stall`  in  1: memory system busy; hold the request.
- `DataOut`  in  DATA_W: memory read data.
- `Busy`  out  1: FSM not IDLE or FIFO not empty.
- `PendingCount`  out  $clog2(DEPTH+1): FIFO occupancy.

## Operation
- FIFO push happens when `ReqValid && ReqReady`. While full, `ReqReady` is 0 and offered requests are not accepted. Push and pop in the same cycle are both allowed; occupancy stays unchanged.
- FSM states are IDLE, ISSUE and GAP.
  - IDLE: strobes are 0. If the FIFO is non-empty, the FSM latches the head into the issue register and moves to ISSUE.
  - ISSUE: the FSM drives exactly one of `MemReadCpu`/`MemWriteCpu` plus `Address` and `DataIn` from the issue register. All four stay constant for the whole state.
  - ISSUE completion: at any rising edge where `Stall` is 0, the request completes. The FSM pops the head, sets `RspValid` to 1, sets `RspData` to `DataOut` (or 0 for a store), sets `RspTimeout` to 0, and moves to GAP.
  - ISSUE abort: at any rising edge where `Stall` is 1 and the stall counter equals TIMEOUT-1, the FSM pops the head, sets `RspValid` and `RspTimeout` to 1, sets `RspData` to 0, and moves to GAP.
  - GAP: strobes are 0 for exactly one cycle so the controller returns to idle. Then the FSM goes to IDLE.
- The stall counter is $clog2(TIMEOUT) bits. It clears on entry to ISSUE, increments on each `Stall`-high edge in ISSUE, and saturates (never wraps).
- Reset mid-request: all outputs go to 0 immediately, the FIFO empties, and the in-flight request is dropped with no response.

## Timing
- Reset values: `ReqReady`=1; `RspValid`, `RspWrite`, `RspTimeout`, `MemReadCpu`, `MemWriteCpu`, `Busy` = 0; `Address`, `DataIn`, `RspData` = 0; `PendingCount`=0.
- Request accepted at edge N into an empty FIFO with the FSM in IDLE:
  - IDLE latch happens at edge N+1.
  - Strobes are high during cycle N+1..N+2.
  - A hit (no stall) completes at edge N+2, and `RspValid` is high during the following cycle.
  - Best-case latency from accept to response is 2 edges.
- Stall of S cycles adds S cycles of latency. A miss fill with S=4 gives 6.
- Back-to-back requests use a throughput of 1 request per 3 cycles (ISSUE, GAP, IDLE) when all hit.
- `RspValid` is a single-cycle pulse, with no backpressure on responses.

## Structure
- Package `mem_req_pkg`: state enum `{IDLE, ISSUE, GAP}` and the request struct `{write, addr, data}`. Default parameter constants also live here.
- Sub-module `req_fifo`: synchronous FIFO with an async-reset pointer. It exposes full, empty, count, push/pop and the head.

## Test plan
- Read hit: push load 0x015 with `Stall`=0 → strobe high for 1 cycle; `RspValid` at accept+2 with `RspData`=`DataOut`=0xDEADBEEF.
- Read miss: push load 0x3F0 with `Stall` held 4 cycles → `MemReadCpu` and `Address` held stable for 5 cycles; one response with the captured data.
- Store: push store 0x002/0x12345678 → `MemWriteCpu`=1 and `DataIn`=0x12345678 until `Stall`=0; response with `RspWrite`=1 and `RspData`=0.
- Queue full: push 5 requests back-to-back with `Stall`=1 → the 5th is refused with `ReqReady`=0 and `PendingCount`=4. After release, 4 responses arrive in order with a GAP between each.
- Timeout: `Stall` stuck at 1 → abort after 64 stall edges; response with `RspTimeout`=1, strobes go to 0, and the next request issues normally.
- Reset mid-ISSUE: assert `RST` → strobes drop to 0 the same cycle, no response, `PendingCount`=0.
